lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_mem_stage_if.sv | 46 ++++
 rtl/lsu_mem_stage.sv | 139 +++++++++++++
 tb/tb_lsu_mem_stage.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Execute-side, data-memory, writeback and trap signals of the LSU memory stage.
// The slave modport is the stage itself; master is whatever surrounds it.
interface lsu_mem_stage_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_load;
  logic                  in_store;
  logic [2:0]            in_funct3;
  logic [31:0]           in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic [4:0]            in_rd;

  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [3:0]            dmem_wmask;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_we;
  logic                  wb_ready;

  logic                  trap;
  logic                  trap_cause;
  logic [31:0]           trap_addr;
  logic                  trap_clr;

  modport slave (
    input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
    input  dmem_rdata, wb_ready, trap_clr,
    output in_ready, dmem_addr, dmem_wdata, dmem_wmask, dmem_we,
    output wb_valid, wb_rd, wb_data, wb_we, trap, trap_cause, trap_addr
  );

  modport master (
    output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
    output dmem_rdata, wb_ready, trap_clr,
    input  in_ready, dmem_addr, dmem_wdata, dmem_wmask, dmem_we,
    input  wb_valid, wb_rd, wb_data, wb_we, trap, trap_cause, trap_addr
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I load/store memory stage: one-entry writeback buffer, byte-lane store/load
// alignment, and a sticky trap for misaligned or illegal accesses.
module lsu_mem_stage #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, FULL, TRAP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] wbData_q;
  logic [4:0]            wbRd_q;
  logic                  wbWe_q;
  logic                  trapCause_q;
  logic [31:0]           trapAddr_q;

  logic                  inReady;
  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic                  fault;
  logic [1:0]            byteOff;
  logic [DATA_WIDTH-1:0] laneWord;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] storeData;
  logic [3:0]            storeMask;

  assign byteOff       = bus.in_addr[1:0];
  assign bus.dmem_addr = bus.in_addr[ADDR_WIDTH+1:2];

  // Illegal encodings take priority over misalignment when reporting the cause.
  always_comb begin
    illegal = bus.in_load & bus.in_store;
    if (bus.in_load) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
        default: illegal = 1'b1;
      endcase
    end
    if (bus.in_store) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010: ;
        default: illegal = 1'b1;
      endcase
    end
    misaligned = ((bus.in_funct3[1:0] == 2'b01) && bus.in_addr[0]) ||
                 ((bus.in_funct3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));
    fault      = (bus.in_load | bus.in_store) & (illegal | misaligned);
  end

  always_comb begin
    laneWord = bus.dmem_rdata >> {byteOff, 3'b000};
    case (bus.in_funct3)
      3'b000:  loadData = {{24{laneWord[7]}}, laneWord[7:0]};
      3'b001:  loadData = {{16{laneWord[15]}}, laneWord[15:0]};
      3'b100:  loadData = {24'b0, laneWord[7:0]};
      3'b101:  loadData = {16'b0, laneWord[15:0]};
      default: loadData = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    case (bus.in_funct3[1:0])
      2'b00: begin
        storeData = {4{bus.in_wdata[7:0]}};
        storeMask = 4'b0001 << byteOff;
      end
      2'b01: begin
        storeData = {2{bus.in_wdata[15:0]}};
        storeMask = 4'b0011 << byteOff;
      end
      default: begin
        storeData = bus.in_wdata;
        storeMask = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // A faulting accept from FULL only happens with wb_ready high, so the old entry has drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = fault ? TRAP : FULL;
      end
      FULL: begin
        if (accept)            state_d = fault ? TRAP : FULL;
        else if (bus.wb_ready) state_d = EMPTY;
      end
      TRAP: begin
        if (bus.trap_clr) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    inReady        = (state_q == EMPTY) || ((state_q == FULL) && bus.wb_ready);
    accept         = bus.in_valid & inReady;
    bus.in_ready   = inReady;
    bus.dmem_we    = accept & bus.in_store & ~fault;
    bus.dmem_wmask = bus.dmem_we ? storeMask : 4'b0000;
    bus.dmem_wdata = storeData;
    bus.wb_valid   = (state_q == FULL);
    bus.trap       = (state_q == TRAP);
    bus.wb_data    = wbData_q;
    bus.wb_rd      = wbRd_q;
    bus.wb_we      = wbWe_q;
    bus.trap_cause = trapCause_q;
    bus.trap_addr  = trapAddr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbData_q    <= '0;
      wbRd_q      <= '0;
      wbWe_q      <= 1'b0;
      trapCause_q <= 1'b0;
      trapAddr_q  <= '0;
    end else if (accept && !fault) begin
      wbData_q <= bus.in_load ? loadData : bus.in_addr;
      wbRd_q   <= bus.in_rd;
      wbWe_q   <= ~bus.in_store;
    end else if (accept) begin
      trapCause_q <= illegal;
      trapAddr_q  <= bus.in_addr;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed corner cases then random traffic,
// compared against a byte-addressed memory model and an expected-writeback queue.
module tb_lsu_mem_stage;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lsu_mem_stage_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus ();

  lsu_mem_stage #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem    [64];
  logic [7:0]  refMem [256];

  assign bus.dmem_rdata = mem[bus.dmem_addr[5:0]];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        checkData;
  } entry_t;

  entry_t      expQ[$];
  bit          trapPend;
  logic        expCause;
  logic [31:0] expTrapAddr;
  int          checks;
  int          passed;
  int          retired;
  int          weCount;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] wordOf(input int idx);
    return {refMem[4*idx+3], refMem[4*idx+2], refMem[4*idx+1], refMem[4*idx]};
  endfunction

  function automatic int sizeOf(input logic [2:0] f3);
    if (f3[1:0] == 2'b01) return 2;
    if (f3[1:0] == 2'b10) return 4;
    return 1;
  endfunction

  task automatic classify(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, output bit flt, output logic cause);
    bit legal;
    bit mis;
    int size;
    if (ld && st)  legal = 1'b0;
    else if (ld)   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else           legal = (f3 inside {3'd0, 3'd1, 3'd2});
    size  = sizeOf(f3);
    mis   = (size > 1) && ((int'(a[1:0]) % size) != 0);
    flt   = (ld || st) && (!legal || mis);
    cause = !legal;
  endtask

  function automatic logic [31:0] loadRef(input logic [2:0] f3, input logic [31:0] a);
    int          i;
    logic [7:0]  b;
    logic [15:0] h;
    i = int'(a[7:0]);
    b = refMem[i];
    h = {refMem[(i+1) % 256], refMem[i]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'b0, b};
      3'd5:    return {16'b0, h};
      default: return {refMem[(i+3) % 256], refMem[(i+2) % 256], h};
    endcase
  endfunction

  task automatic applyStimulus(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                               input logic wbr, input logic clr);
    bus.in_valid  = v;
    bus.in_load   = ld;
    bus.in_store  = st;
    bus.in_funct3 = f3;
    bus.in_addr   = a;
    bus.in_wdata  = wd;
    bus.in_rd     = rd;
    bus.wb_ready  = wbr;
    bus.trap_clr  = clr;
    #1;
  endtask

  // Checks this cycle's outputs against the model, clocks once, then advances the model.
  task automatic stepCycle();
    bit          expReady;
    bit          acc;
    bit          retire;
    bit          flt;
    bit          expWe;
    logic        cause;
    int          size;
    logic [3:0]  expMask;
    logic        sWe;
    logic [3:0]  sMask;
    logic [31:0] sData;
    logic [5:0]  sIdx;
    logic [31:0] a;
    entry_t      e;

    a        = bus.in_addr;
    expReady = !trapPend && (expQ.size() == 0 || bus.wb_ready);
    checkOutput("inReady", bus.in_ready, expReady);
    checkOutput("wbValid", bus.wb_valid, expQ.size() != 0);
    checkOutput("trap", bus.trap, trapPend);
    if (trapPend) begin
      checkOutput("trapCause", bus.trap_cause, expCause);
      checkOutput("trapAddr", bus.trap_addr, expTrapAddr);
    end
    if (expQ.size() != 0) begin
      checkOutput("wbRd", bus.wb_rd, expQ[0].rd);
      checkOutput("wbWe", bus.wb_we, expQ[0].we);
      if (expQ[0].checkData) checkOutput("wbData", bus.wb_data, expQ[0].data);
    end

    acc    = bus.in_valid && expReady;
    retire = (expQ.size() != 0) && bus.wb_ready;
    classify(bus.in_load, bus.in_store, bus.in_funct3, a, flt, cause);
    size    = sizeOf(bus.in_funct3);
    expWe   = acc && bus.in_store && !flt;
    expMask = expWe ? 4'(((1 << size) - 1) << a[1:0]) : 4'b0000;
    checkOutput("dmemWe", bus.dmem_we, expWe);
    checkOutput("dmemMask", bus.dmem_wmask, expMask);
    if (acc && (bus.in_load || bus.in_store) && !flt)
      checkOutput("dmemAddr", bus.dmem_addr, a[16:2]);

    sWe   = bus.dmem_we;
    sMask = bus.dmem_wmask;
    sData = bus.dmem_wdata;
    sIdx  = bus.dmem_addr[5:0];

    e.rd        = bus.in_rd;
    e.we        = 1'b1;
    e.checkData = 1'b1;
    e.data      = a;
    if (acc && !flt && bus.in_load) e.data = loadRef(bus.in_funct3, a);

    @(posedge clk);
    #1;

    if (sWe) begin
      weCount++;
      for (int l = 0; l < 4; l++)
        if (sMask[l]) mem[sIdx][8*l +: 8] = sData[8*l +: 8];
    end

    if (retire) begin
      void'(expQ.pop_front());
      retired++;
    end
    if (trapPend && bus.trap_clr) trapPend = 1'b0;
    if (acc) begin
      if (flt) begin
        trapPend    = 1'b1;
        expCause    = cause;
        expTrapAddr = a;
      end else if (bus.in_store) begin
        for (int k = 0; k < size; k++)
          refMem[(int'(a[7:0]) + k) % 256] = bus.in_wdata[8*k +: 8];
        e.we        = 1'b0;
        e.checkData = 1'b0;
        expQ.push_back(e);
        checkOutput("memAfterStore", mem[a[7:2]], wordOf(int'(a[7:2])));
      end else begin
        expQ.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          r0;
    int          r1;
    int          kind;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] w;

    checks   = 0;
    passed   = 0;
    retired  = 0;
    weCount  = 0;
    trapPend = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w      = $urandom;
      mem[i] = w;
      for (int k = 0; k < 4; k++) refMem[4*i+k] = w[8*k +: 8];
    end
    mem[0] = 32'h80F0_1234;
    refMem[0] = 8'h34; refMem[1] = 8'h12; refMem[2] = 8'hF0; refMem[3] = 8'h80;

    applyStimulus(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rstWbValid", bus.wb_valid, 1'b0);
    checkOutput("rstTrap", bus.trap, 1'b0);
    checkOutput("rstTrapAddr", bus.trap_addr, 32'h0);
    checkOutput("rstWbData", bus.wb_data, 32'h0);
    checkOutput("rstInReady", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Sign/zero-extended sub-word loads from a known word
    applyStimulus(1, 1, 0, 3'd0, 32'h3, 32'h0, 5'd1, 1'b1, 1'b0);
    stepCycle();
    checkOutput("lbData", bus.wb_data, 32'hFFFF_FF80);
    applyStimulus(1, 1, 0, 3'd4, 32'h3, 32'h0, 5'd2, 1'b1, 1'b0);
    stepCycle();
    checkOutput("lbuData", bus.wb_data, 32'h0000_0080);
    applyStimulus(1, 1, 0, 3'd1, 32'h2, 32'h0, 5'd3, 1'b1, 1'b0);
    stepCycle();
    checkOutput("lhData", bus.wb_data, 32'hFFFF_80F0);

    // Byte store lane replication
    applyStimulus(1, 0, 1, 3'd0, 32'h6, 32'hAB, 5'd4, 1'b1, 1'b0);
    checkOutput("sbWdata", bus.dmem_wdata, 32'hABAB_ABAB);
    checkOutput("sbMask", bus.dmem_wmask, 4'b0100);
    checkOutput("sbAddr", bus.dmem_addr, 15'd1);
    stepCycle();

    // Misaligned word load traps until cleared
    applyStimulus(1, 1, 0, 3'd2, 32'h2, 32'h0, 5'd7, 1'b1, 1'b0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 3'd2, 32'h4, 32'h0, 5'd7, 1'b1, 1'b0);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    checkOutput("misTrapCause", bus.trap_cause, 1'b0);
    checkOutput("misTrapAddr", bus.trap_addr, 32'h2);
    stepCycle();
    applyStimulus(1, 1, 0, 3'd2, 32'h4, 32'h0, 5'd8, 1'b1, 1'b0);
    checkOutput("inReadyAfterClr", bus.in_ready, 1'b1);
    stepCycle();

    // Back-to-back loads with a three-cycle writeback stall
    r0 = retired;
    applyStimulus(1, 1, 0, 3'd2, 32'h10, 32'h0, 5'd1, 1'b1, 1'b0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 3'd4, 32'h11, 32'h0, 5'd2, 1'b0, 1'b0);
      stepCycle();
    end
    applyStimulus(1, 1, 0, 3'd4, 32'h11, 32'h0, 5'd2, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1, 1, 0, 3'd5, 32'h12, 32'h0, 5'd3, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("b2bRetired", retired - r0, 32'd4);

    // Store held off behind a stalled entry writes exactly once
    r1 = weCount;
    applyStimulus(1, 1, 0, 3'd2, 32'h20, 32'h0, 5'd5, 1'b1, 1'b0);
    stepCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 1, 3'd2, 32'h24, 32'hCAFE_F00D, 5'd6, 1'b0, 1'b0);
      stepCycle();
    end
    applyStimulus(1, 0, 1, 3'd2, 32'h24, 32'hCAFE_F00D, 5'd6, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("storeOnce", weCount - r1, 32'd1);

    // Asynchronous reset in the middle of a stall
    applyStimulus(1, 1, 0, 3'd2, 32'h30, 32'h0, 5'd9, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstWbValid", bus.wb_valid, 1'b0);
    checkOutput("midRstWbRd", bus.wb_rd, 5'd0);
    checkOutput("midRstWbWe", bus.wb_we, 1'b0);
    checkOutput("midRstWe", bus.dmem_we, 1'b0);
    expQ.delete();
    trapPend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    stepCycle();

    for (int n = 0; n < 1500; n++) begin
      kind = int'($urandom_range(0, 9));
      ld   = (kind <= 3) || (kind == 9);
      st   = (kind >= 4 && kind <= 6) || (kind == 9 && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0)  f3 = 3'($urandom);
      else if (st)                    f3 = 3'($urandom_range(0, 2));
      else                            f3 = ($urandom_range(0, 4) > 2) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2));
      if (ld || st) begin
        a = 32'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 9) < 3) a[1:0] = 2'($urandom);
        else if (sizeOf(f3) == 1)     a[1:0] = 2'($urandom);
        else if (sizeOf(f3) == 2)     a[1]   = 1'($urandom);
      end else begin
        a = $urandom;
      end
      applyStimulus($urandom_range(0, 3) != 0, ld, st, f3, a, $urandom, 5'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
      stepCycle();
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
      stepCycle();
    end
    for (int i = 0; i < 64; i++) checkOutput("memWord", mem[i], wordOf(i));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
